// File: rtl/logicnet_quant_pkg.sv
// -----------------------------------------------------------------------------
// logicnet_quant_pkg
// Shared definitions for the LogicNets input quantizer:
//   CODE_W_DEFAULT / NTHR_DEFAULT - default code width and thresholds/feature
//   quant_state_e                 - collector FSM states
//   thr_addr()                    - flat threshold index feature*nthr + k
// -----------------------------------------------------------------------------
package logicnet_quant_pkg;

    localparam int CODE_W_DEFAULT = 2;
    localparam int NTHR_DEFAULT   = (2 ** CODE_W_DEFAULT) - 1;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } quant_state_e;

    // Thresholds are stored feature-major, NTHR entries per feature.
    function automatic int thr_addr(input int feature, input int k, input int nthr);
        return (feature * nthr) + k;
    endfunction

endpackage

// File: rtl/logicnet_thermo_quant.sv
// -----------------------------------------------------------------------------
// logicnet_thermo_quant
// Combinational thermometer-count quantizer: code = number of thresholds the
// feature value is greater than or equal to (unsigned). Thresholds need not be
// sorted.
// Ports:
//   feat [FEAT_W]          raw feature value
//   thr  [NTHR][FEAT_W]    thresholds of this feature
//   code [CODE_W]          resulting count, 0..NTHR
// -----------------------------------------------------------------------------
module logicnet_thermo_quant
    import logicnet_quant_pkg::*;
#(
    parameter int FEAT_W = 16,
    parameter int CODE_W = CODE_W_DEFAULT,
    parameter int NTHR   = NTHR_DEFAULT
) (
    input  logic [FEAT_W-1:0]            feat,
    input  logic [NTHR-1:0][FEAT_W-1:0]  thr,
    output logic [CODE_W-1:0]            code
);

    // Population count of the threshold compares.
    always_comb begin
        code = '0;
        for (int k = 0; k < NTHR; k++) begin
            if (feat >= thr[k]) begin
                code = code + CODE_W'(1);
            end else begin
                code = code;
            end
        end
    end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// -----------------------------------------------------------------------------
// logicnet_input_quantizer
// Collects NUM_FEATURES serial feature words, quantizes each against its
// programmable thresholds and presents the packed code vector downstream.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last   feature stream in
//   m_valid/m_ready/m_data    packed code vector out (feature i at [i*CODE_W +: CODE_W])
//   cfg_we/cfg_addr/cfg_data  threshold write port, index = feature*NTHR + k
//   err                       framing error pulse
// Build option:
//   LOGICNET_QUANT_LAST_CHECK_EN - check s_last against the feature count and
//   pulse err on mismatch; when undefined s_last is ignored and err stays 0.
// -----------------------------------------------------------------------------
module logicnet_input_quantizer
    import logicnet_quant_pkg::*;
#(
    parameter  int NUM_FEATURES = 16,
    parameter  int FEAT_W       = 16,
    parameter  int CODE_W       = CODE_W_DEFAULT,
    localparam int NTHR         = (2 ** CODE_W) - 1,
    localparam int NUM_THR      = NUM_FEATURES * NTHR,
    localparam int CFG_AW       = $clog2(NUM_THR),
    localparam int IDX_W        = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [FEAT_W-1:0]              s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_FEATURES*CODE_W-1:0] m_data,
    input  logic                           cfg_we,
    input  logic [CFG_AW-1:0]              cfg_addr,
    input  logic [FEAT_W-1:0]              cfg_data,
    output logic                           err
);

    quant_state_e                    state_r;
    logic [IDX_W-1:0]                idx_r;
    logic                            s_ready_r;
    logic                            m_valid_r;
    logic                            err_r;
    logic [NUM_FEATURES*CODE_W-1:0]  m_data_r;
    logic [FEAT_W-1:0]               thr_r [NUM_THR];
    logic [NTHR-1:0][FEAT_W-1:0]     thr_sel_s;
    logic [CODE_W-1:0]               code_s;
    logic                            accept_s;
    logic                            last_idx_s;

    assign accept_s   = s_valid && s_ready_r;
    assign last_idx_s = (idx_r == IDX_W'(NUM_FEATURES - 1));

`ifndef LOGICNET_QUANT_LAST_CHECK_EN
    logic unused_s_last_s;
    assign unused_s_last_s = s_last;
`endif

    // Threshold register file; same-edge writes are seen by compares next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THR; i++) begin
                thr_r[i] <= '1;
            end
        end else if (cfg_we && (int'(cfg_addr) < NUM_THR)) begin
            thr_r[cfg_addr] <= cfg_data;
        end
    end

    // Select the thresholds belonging to the feature currently being collected.
    always_comb begin
        thr_sel_s = '0;
        for (int k = 0; k < NTHR; k++) begin
            thr_sel_s[k] = thr_r[CFG_AW'(thr_addr(int'(idx_r), k, NTHR))];
        end
    end

    logicnet_thermo_quant #(
        .FEAT_W (FEAT_W),
        .CODE_W (CODE_W),
        .NTHR   (NTHR)
    ) u_thermo_quant (
        .feat (s_data),
        .thr  (thr_sel_s),
        .code (code_s)
    );

    // Collector FSM: buffer codes, hand the full vector downstream, registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= COLLECT;
            idx_r     <= '0;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                COLLECT: begin
                    s_ready_r <= 1'b1;
                    if (accept_s) begin
                        // The output register doubles as the collection buffer;
                        // it is only observed once m_valid is raised.
                        m_data_r[int'(idx_r)*CODE_W +: CODE_W] <= code_s;
                        if (last_idx_s) begin
                            idx_r     <= '0;
                            state_r   <= HOLD;
                            m_valid_r <= 1'b1;
                            s_ready_r <= 1'b0;
`ifdef LOGICNET_QUANT_LAST_CHECK_EN
                            err_r     <= !s_last;
`endif
                        end else begin
`ifdef LOGICNET_QUANT_LAST_CHECK_EN
                            if (s_last) begin
                                // Early end of frame: drop the partial vector.
                                err_r <= 1'b1;
                                idx_r <= '0;
                            end else begin
                                idx_r <= idx_r + IDX_W'(1);
                            end
`else
                            idx_r <= idx_r + IDX_W'(1);
`endif
                        end
                    end
                end
                HOLD: begin
                    s_ready_r <= 1'b0;
                    if (m_ready) begin
                        m_valid_r <= 1'b0;
                        state_r   <= COLLECT;
                        s_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= COLLECT;
                    idx_r     <= '0;
                    s_ready_r <= 1'b0;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign err     = err_r;

endmodule
